// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_r;
    logic [2*W-1:0] acc;
    logic [W-1:0]   rb;
    logic [W-1:0]   ra;
    logic           sa, sb, dz;

    logic [W-1:0]   amag, bmag;
    logic [W:0]     madd, rsh;
    logic [W-1:0]   rsub;
    logic           ge;
    logic [2*W-1:0] step, pneg;
    logic [W-1:0]   qfix, rfix;

    always_comb begin
        amag = (!op[0] && srca[W-1]) ? -srca : srca;
        bmag = (!op[0] && srcb[W-1]) ? -srcb : srcb;
        madd = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, rb} : '0);
        rsh  = {acc[2*W-1:W], acc[W-1]};
        ge   = rsh >= {1'b0, rb};
        // low bits suffice: rsub is only used when rsh >= rb
        rsub = rsh[W-1:0] - rb;
        if (op_r[1])
            step = {(ge ? rsub : rsh[W-1:0]), acc[W-2:0], ge};
        else
            step = {madd, acc[W-1:1]};
        pneg = -acc;
        qfix = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
        rfix = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_r    <= '0;
            acc     <= '0;
            rb      <= '0;
            ra      <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        ra    <= srca;
                        rb    <= op[1] ? bmag : amag;
                        acc   <= {{W{1'b0}}, (op[1] ? amag : bmag)};
                        sa    <= !op[0] && srca[W-1];
                        sb    <= !op[0] && srcb[W-1];
                        dz    <= op[1] && (srcb == '0);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1))
                        state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        hi <= ra;
                        lo <= '1;
                    end else if (op_r[1]) begin
                        hi <= rfix;
                        lo <= qfix;
                    end else if (sa ^ sb) begin
                        {hi, lo} <= pneg;
                    end else begin
                        {hi, lo} <= acc;
                    end
                    done    <= 1'b1;
                    divzero <= dz;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
